// File: rtl/mult_result_display_pkg.sv
// Shared types and 7-segment encodings for the multiplier result display.
package mult_result_display_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}
    function automatic logic [35:0] dd_step(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int i = 0; i < 5; i++) begin
            if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/mult_result_display_bin2bcd_seq.sv
// Sequential 16-bit double-dabble converter with start/busy/valid and a one-deep
// "latest wins" pending slot for starts that arrive while busy.
module mult_result_display_bin2bcd_seq
    import mult_result_display_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] din_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [19:0] result_o
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [35:0] sreg_q, sreg_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [19:0] result_q, result_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sreg_d  = {20'b0, din_i};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == 5'(CONV_CYCLES)) begin
                    result_d = sreg_q[35:16];
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    sreg_d = dd_step(sreg_q);
                    cnt_d  = cnt_q + 5'd1;
                end
                if (start_i) begin
                    pend_d     = 1'b1;
                    pend_val_d = din_i;
                end
            end
            DONE: begin
                // A fresh start here is newer than anything pending, so it wins.
                if (start_i || pend_q) begin
                    sreg_d  = {20'b0, start_i ? din_i : pend_val_q};
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: rtl/mult_result_display.sv
// Product-to-BCD converter and 8-position multiplexed 7-segment scanner.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on positions 1..4.
module mult_result_display
    import mult_result_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned CONV_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_out,
    input  logic        done_flag,
    output logic        busy,
    output logic        bcd_valid,
    output logic [19:0] bcd_digits,
    output logic [7:0]  seg_position,
    output logic [7:0]  seg_data
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic            done_d_q;
    logic            start;
    logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      pos_q, pos_d;
    logic [7:0]      data_q, data_d;

    assign start = done_flag & ~done_d_q;

    mult_result_display_bin2bcd_seq #(
        .CONV_CYCLES(CONV_CYCLES)
    ) u_bin2bcd (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .din_i   (d_out),
        .busy_o  (busy),
        .valid_o (bcd_valid),
        .result_o(bcd_digits)
    );

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == CntW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end
        // Position and data are both derived from idx_q so they switch on one edge.
        pos_d = ~(8'd1 << idx_q);
        unique case (idx_q)
            3'd0:    data_d = seg_encode(bcd_digits[3:0]);
            3'd1:    data_d = seg_encode(bcd_digits[7:4]);
            3'd2:    data_d = seg_encode(bcd_digits[11:8]);
            3'd3:    data_d = seg_encode(bcd_digits[15:12]);
            3'd4:    data_d = seg_encode(bcd_digits[19:16]);
            default: data_d = SEG_BLANK;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 3'd1 && bcd_digits[19:4] == '0) ||
            (idx_q == 3'd2 && bcd_digits[19:8] == '0) ||
            (idx_q == 3'd3 && bcd_digits[19:12] == '0) ||
            (idx_q == 3'd4 && bcd_digits[19:16] == '0)) begin
            data_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d_q   <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            pos_q      <= 8'hFF;
            data_q     <= 8'hFF;
        end else begin
            done_d_q   <= done_flag;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            data_q     <= data_d;
        end
    end

    assign seg_position = pos_q;
    assign seg_data     = data_q;

endmodule

// File: tb/tb_mult_result_display.sv
// Scoreboard bench for mult_result_display: driver queues expected BCD results and
// arrival cycles; a negedge monitor pops and checks on every bcd_valid pulse.
module tb_mult_result_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_out;
    logic        done_flag;
    logic        busy;
    logic        bcd_valid;
    logic [19:0] bcd_digits;
    logic [7:0]  seg_position;
    logic [7:0]  seg_data;

    typedef struct {
        logic [19:0] digits;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mult_result_display #(
        .SCAN_DIV(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_out       (d_out),
        .done_flag   (done_flag),
        .busy        (busy),
        .bcd_valid   (bcd_valid),
        .bcd_digits  (bcd_digits),
        .seg_position(seg_position),
        .seg_data    (seg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bcd_valid cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bcd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {12'b0, bcd_digits}, 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd_digits", {12'b0, bcd_digits}, {12'b0, e.digits});
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Pulse done_flag for one clock; returns the cycle count before edge k.
    task automatic pulse(input logic [15:0] val, output int c);
        @(posedge clk); #1;
        d_out     = val;
        done_flag = 1'b1;
        c         = cyc;
        @(posedge clk); #1;
        done_flag = 1'b0;
    endtask

    task automatic wait_results();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_pos(input string name, input int p, input logic [7:0] exp);
        logic [7:0] m;
        int n;
        m = ~(8'd1 << p);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (seg_position !== m && n < 100);
        if (seg_position !== m) chk({name, "_pos_timeout"}, seg_position, m);
        else chk(name, seg_data, exp);
    endtask

    initial begin
        int c, c1;
        logic [7:0] prev, m;
        rst       = 1'b1;
        d_out     = '0;
        done_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", bcd_valid, 0);
        chk("rst_digits", bcd_digits, 0);
        chk("rst_segpos", seg_position, 8'hFF);
        chk("rst_segdata", seg_data, 8'hFF);
        rst = 1'b0;

        // Scanner: each position held 4 clocks, FE..7F then back to FE.
        prev = seg_position;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (seg_position == 8'hFE && prev != 8'hFE) break;
            prev = seg_position;
        end
        chk("scan_start", seg_position, 8'hFE);
        for (int s = 0; s < 9; s++) begin
            m = ~(8'd1 << (s % 8));
            for (int h = 0; h < 4; h++) begin
                if (s != 0 || h != 0) @(negedge clk);
                chk("scan_seq", seg_position, m);
            end
        end

        // 129*19 = 2451
        pulse(16'd2451, c);
        sb.push_back('{20'h02451, c + 18});
        repeat (3) @(negedge clk);
        chk("busy_conv", busy, 1);
        chk("hold_during_conv", bcd_digits, 20'h00000);
        wait_results();
        chk("busy_idle", busy, 0);
        check_pos("p0_2451", 0, 8'hF9);
        check_pos("p1_2451", 1, 8'h92);
        check_pos("p2_2451", 2, 8'h99);
        check_pos("p3_2451", 3, 8'hA4);
`ifdef LEADING_ZERO_BLANK_EN
        check_pos("p4_2451", 4, 8'hFF);
`else
        check_pos("p4_2451", 4, 8'hC0);
`endif

        // Maximum product
        pulse(16'd65025, c);
        sb.push_back('{20'h65025, c + 18});
        wait_results();
        check_pos("p4_65025", 4, 8'h82);
        check_pos("p5_65025", 5, 8'hFF);
        check_pos("p6_65025", 6, 8'hFF);
        check_pos("p7_65025", 7, 8'hFF);

        // Second edge 5 clocks after the first is held pending
        pulse(16'd100, c1);
        sb.push_back('{20'h00100, c1 + 18});
        repeat (3) @(posedge clk);
        pulse(16'd200, c);
        sb.push_back('{20'h00200, c1 + 36});
        wait_results();
        chk("final_200", bcd_digits, 20'h00200);

        // Three rapid edges during CONV: only the last converts next
        pulse(16'd300, c1);
        sb.push_back('{20'h00300, c1 + 18});
        pulse(16'd111, c);
        pulse(16'd222, c);
        pulse(16'd333, c);
        sb.push_back('{20'h00333, c1 + 36});
        wait_results();

        // Reset at CONV iteration 8 aborts with no valid pulse
        pulse(16'd777, c);
        repeat (8) @(posedge clk);
        #1;
        chk("hold_before_rst", bcd_digits, 20'h00333);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", bcd_valid, 0);
        chk("midrst_digits", bcd_digits, 0);
        chk("midrst_segpos", seg_position, 8'hFF);
        chk("midrst_segdata", seg_data, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        pulse(16'd4321, c);
        sb.push_back('{20'h04321, c + 18});
        wait_results();

        // 42: leading-zero handling
        pulse(16'd42, c);
        sb.push_back('{20'h00042, c + 18});
        wait_results();
        check_pos("p0_42", 0, 8'hA4);
        check_pos("p1_42", 1, 8'h99);
`ifdef LEADING_ZERO_BLANK_EN
        check_pos("p2_42", 2, 8'hFF);
        check_pos("p3_42", 3, 8'hFF);
        check_pos("p4_42", 4, 8'hFF);
`else
        check_pos("p2_42", 2, 8'hC0);
        check_pos("p3_42", 3, 8'hC0);
        check_pos("p4_42", 4, 8'hC0);
`endif

        // Zero product: position 0 always shown
        pulse(16'd0, c);
        sb.push_back('{20'h00000, c + 18});
        wait_results();
        check_pos("p0_zero", 0, 8'hC0);
`ifdef LEADING_ZERO_BLANK_EN
        check_pos("p1_zero", 1, 8'hFF);
`else
        check_pos("p1_zero", 1, 8'hC0);
`endif

        repeat (40) @(posedge clk);
        chk("no_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
